// File: rtl/piso_shift_tx.sv
// ---------------------------------------------------------------------------
// piso_shift_tx
//   Parallel-in serial-out transmitter. It loads a word through a valid/ready
//   handshake and shifts it out MSB first on `so`. The block sits upstream of
//   the 4-bit SIPO left-shift register and drives its `si` input.
//   After a frame, GAP_CYCLES idle bit-times pass before the next load.
//
//   Optional feature: define PISO_PARITY_EN to append one even-parity bit
//   (^din of the captured word) after the data LSB. The frame is then
//   WIDTH+1 bits long.
//
// Parameters
//   WIDTH       data word width (>= 2)
//   GAP_CYCLES  idle cycles after each frame (0 allowed)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   din        parallel word to transmit
//   din_valid  din holds a word to send
//   din_ready  block accepts a word this cycle (IDLE only)
//   so         serial data out, MSB first
//   so_valid   so carries a frame bit this cycle
//   busy       frame or gap in progress
//   done       one-cycle pulse on the final frame bit
//
// All outputs are registered. The next-state block computes the value each
// output must hold in the following cycle.
// ---------------------------------------------------------------------------
module piso_shift_tx #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    // The bit counter must be able to hold the value FRAME_LEN.
    localparam int CW = $clog2(FRAME_LEN + 1);
    // The gap counter counts 0..GAP_CYCLES-1. Its width is kept at one bit
    // or more, so the GAP_CYCLES=0 build still elaborates cleanly.
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [FRAME_LEN-1:0] shreg, shreg_nxt;
    logic [FRAME_LEN-1:0] load_word;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [GW-1:0]        gcnt, gcnt_nxt;
    logic                 so_nxt, so_valid_nxt, busy_nxt, done_nxt, din_ready_nxt;
    logic                 handshake;

    // The shift register holds the complete frame, so the parity bit (when
    // present) shifts out through the same path as the data bits.
`ifdef PISO_PARITY_EN
    assign load_word = {din, ^din};
`else
    assign load_word = din;
`endif

    assign handshake = din_valid && din_ready;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            gcnt      <= '0;
            so        <= 1'b0;
            so_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            din_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            gcnt      <= gcnt_nxt;
            so        <= so_nxt;
            so_valid  <= so_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            din_ready <= din_ready_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and next registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        cnt_nxt       = cnt;
        gcnt_nxt      = gcnt;
        so_nxt        = 1'b0;
        so_valid_nxt  = 1'b0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        din_ready_nxt = 1'b0;

        case (state)
            IDLE: begin
                din_ready_nxt = 1'b1;
                if (handshake) begin
                    // Capture the word. The MSB appears on so in the very
                    // next cycle.
                    state_nxt     = SHIFT;
                    shreg_nxt     = load_word;
                    cnt_nxt       = CW'(1);
                    so_nxt        = load_word[FRAME_LEN-1];
                    so_valid_nxt  = 1'b1;
                    busy_nxt      = 1'b1;
                    din_ready_nxt = 1'b0;
                end
            end

            SHIFT: begin
                if (cnt == CW'(FRAME_LEN)) begin
                    // The final bit was on so this cycle. Leave the frame.
                    cnt_nxt   = '0;
                    shreg_nxt = '0;
                    gcnt_nxt  = '0;
                    if (GAP_CYCLES == 0) begin
                        state_nxt     = IDLE;
                        din_ready_nxt = 1'b1;
                    end else begin
                        state_nxt = GAP;
                        busy_nxt  = 1'b1;
                    end
                end else begin
                    shreg_nxt    = shreg << 1;
                    so_nxt       = shreg_nxt[FRAME_LEN-1];
                    so_valid_nxt = 1'b1;
                    busy_nxt     = 1'b1;
                    cnt_nxt      = cnt + CW'(1);
                    done_nxt     = (cnt_nxt == CW'(FRAME_LEN));
                end
            end

            GAP: begin
                busy_nxt = 1'b1;
                if (gcnt == GW'(GAP_CYCLES - 1)) begin
                    state_nxt     = IDLE;
                    busy_nxt      = 1'b0;
                    din_ready_nxt = 1'b1;
                    gcnt_nxt      = '0;
                end else begin
                    gcnt_nxt = gcnt + GW'(1);
                end
            end

            default: begin
                state_nxt     = IDLE;
                din_ready_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_shift_tx
//   Self-checking bench for piso_shift_tx (WIDTH=4).
//   dut  : GAP_CYCLES=1. Driven from a vector table. A scoreboard checks every
//          serial bit, done, the downstream SIPO word and the gap length.
//   dut0 : GAP_CYCLES=0. Used for the cycle-exact back-to-back sequence.
//   Define PISO_PARITY_EN for both the RTL and this file to cover parity.
// ---------------------------------------------------------------------------
module tb_piso_shift_tx;
    localparam int W   = 4;
    localparam int GAP = 1;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [W-1:0] din, din0;
    logic         din_valid, din_valid0;
    logic         din_ready, so, so_valid, busy, done;
    logic         din_ready0, so0, so_valid0, busy0, done0;

    piso_shift_tx #(.WIDTH(W), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .so(so), .so_valid(so_valid),
        .busy(busy), .done(done)
    );

    piso_shift_tx #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .din(din0), .din_valid(din_valid0),
        .din_ready(din_ready0), .so(so0), .so_valid(so_valid0),
        .busy(busy0), .done(done0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic         b;
        logic         last;
        logic [W-1:0] po;
    } exp_t;
    exp_t sbq[$];
    exp_t em;

    typedef struct {
        logic [W-1:0] din;
        logic         par;
    } vec_t;

    // Frame bits with the first-sent bit at index FL-1.
    function automatic logic [FL-1:0] frame_bits(input logic [W-1:0] d, input logic par);
        logic [W:0] full;
        full = {d, par};
        return full[W -: FL];
    endfunction

    task automatic push_frame(input logic [W-1:0] d, input logic par);
        logic [FL-1:0] f;
        exp_t          e;
        f = frame_bits(d, par);
        for (int i = 0; i < FL; i++) begin
            e.b    = f[FL-1-i];
            e.last = (i == FL - 1);
            e.po   = f[W-1:0];     // last W bits shifted into the SIPO
            sbq.push_back(e);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic par);
        bit ok;
        ok = 0;
        @(negedge clk);
        din       = d;
        din_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (din_ready === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("handshake_timeout", 0, 1);
            din_valid = 1'b0;
            return;
        end
        push_frame(d, par);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = ~d;            // must not disturb the frame in flight
        @(negedge clk);
        check("first_bit_latency", so_valid, 1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (sbq.size() == 0 && busy === 1'b0) begin
                repeat (3) @(negedge clk);
                return;
            end
        end
        check("idle_timeout", 0, 1);
    endtask

    // Downstream 4-bit SIPO left-shift register, fed only with valid bits.
    logic [W-1:0] po;
    always @(posedge clk) begin
        if (rst)           po <= '0;
        else if (so_valid) po <= {po[W-2:0], so};
    end

    // Monitor and scoreboard for dut.
    logic         po_chk;
    logic [W-1:0] po_exp;
    int           gap_run;
    bit           saw_done, prev_busy;
    always @(negedge clk) begin
        if (rst) begin
            po_chk    = 1'b0;
            gap_run   = 0;
            saw_done  = 0;
            prev_busy = 0;
        end else begin
            if (po_chk) begin
                check("sipo_po", po, po_exp);
                po_chk = 1'b0;
            end
            check("ready_vs_busy", din_ready, !busy);
            if (so_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    em = sbq.pop_front();
                    check("so_bit", so, em.b);
                    check("done_pos", done, em.last);
                    check("busy_in_frame", busy, 1);
                    if (em.last) begin
                        po_chk = 1'b1;
                        po_exp = em.po;
                    end
                end
                gap_run  = 0;
                saw_done = done;
            end else begin
                check("idle_so_done", {so, done}, 2'b00);
                if (busy) gap_run++;
                else if (prev_busy && saw_done) begin
                    check("gap_len", gap_run, GAP);
                    saw_done = 0;
                    gap_run  = 0;
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        vec_t          vecs[10];
        logic [FL-1:0] f1, f2;
        logic          eb, ev, ed, er, ebz;

        vecs = '{
            '{4'b1011, 1'b1}, '{4'b0110, 1'b0}, '{4'b1000, 1'b1}, '{4'b0001, 1'b1},
            '{4'b1111, 1'b0}, '{4'b0101, 1'b0}, '{4'b1001, 1'b0}, '{4'b1110, 1'b1},
            '{4'b0000, 1'b0}, '{4'b1100, 1'b0}
        };

        rst = 1'b1; din = '0; din_valid = 1'b0; din0 = '0; din_valid0 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_so", so, 0);
        check("rst_so_valid", so_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_din_ready", din_ready, 1);

        // Back-to-back on dut0 (GAP_CYCLES=0): one idle cycle between frames.
        // din is held valid, so the second word loads in the first IDLE cycle.
        f1 = frame_bits(4'b1000, 1'b1);
        f2 = frame_bits(4'b0001, 1'b1);
        din0 = 4'b1000; din_valid0 = 1'b1;
        check("b2b_ready_start", din_ready0, 1);
        @(posedge clk);
        #1 din0 = 4'b0001;
        for (int k = 1; k <= 2 * FL + 1; k++) begin
            @(negedge clk);
            if (k <= FL) begin
                eb = f1[FL-k]; ev = 1; ed = (k == FL); er = 0; ebz = 1;
            end else if (k == FL + 1) begin
                eb = 0; ev = 0; ed = 0; er = 1; ebz = 0;
            end else begin
                eb = f2[FL-(k-FL-1)]; ev = 1; ed = (k == 2 * FL + 1); er = 0; ebz = 1;
            end
            check("b2b_so_vld_done_rdy_busy", {so0, so_valid0, done0, din_ready0, busy0},
                  {eb, ev, ed, er, ebz});
            if (k == FL + 2) din_valid0 = 1'b0;
        end

        // Vector table on dut. Entry 1 is driven while entry 0 is still in
        // flight, so it must wait for IDLE and must not be captured early.
        foreach (vecs[i]) send(vecs[i].din, vecs[i].par);
        wait_idle();

        // Reset mid-frame: reset lands at the end of the second bit.
        send(4'b1111, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        check("midrst_so", so, 0);
        check("midrst_so_valid", so_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_din_ready", din_ready, 1);
        send(4'b0101, 1'b0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
